cache_ri_refill: RTL and testbench
==================================

Name: cache_ri_refill

Overview:
- Line-refill engine for the data cache, directly upstream of the per-byte readable-bit store; it drives that store's ri_* port group and its sel input.
- On a miss request it fetches one cache line word by word from the memory bus and writes the data RAM.
- Bytes already marked readable, i.e. written by the CPU before the refill, are never overwritten.
- After each word it sets that word's 4 readable bits.

Parameters:
- ADDR_WIDTH, 9, word address width into data RAM and readable-bit store; bit 0 selects the half of an 8-bit readable byte.
- LINE_WORDS, 8, 32-bit words per line; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  refill request
- req_ready  out  1  high in IDLE only
- req_channel  in  2  way to refill
- req_address  in  ADDR_WIDTH  line-base word address, aligned to LINE_WORDS
- req_memAddress  in  32  byte address of the line base in memory
- done  out  1  one-cycle pulse when the refill completes
- sel  out  1  owns the readable-bit store and data-RAM write port while high
- ri_readAddress  out  ADDR_WIDTH  readable-bit read address
- ri_readChannel  out  2  readable-bit read channel
- ri_readData  in  8  readable byte, valid 1 cycle after the address is presented
- ri_readRe  in  4  readable bits of the addressed word, same timing as ri_readData
- ri_writeAddress  out  ADDR_WIDTH  readable-bit write address
- ri_writeChannel  out  2  readable-bit write channel
- ri_writeEnable  out  1  readable-bit write strobe
- ri_writeData  out  8  readable byte to write
- mem_address  out  32  memory word byte address
- mem_read  out  1  memory read request
- mem_waitRequest  in  1  memory stall; the request is held while high
- mem_readDataValid  in  1  read data return strobe
- mem_readData  in  32  read data
- dat_writeAddress  out  ADDR_WIDTH  data RAM word address
- dat_writeChannel  out  2  data RAM way
- dat_writeData  out  32  data RAM write data
- dat_writeByteEnable  out  4  data RAM byte enables
- dat_writeEnable  out  1  data RAM write strobe

Behaviour:
- Reset: state IDLE, word counter 0, and all outputs 0 except req_ready=1.
- Reset mid-refill aborts immediately. Partially written words keep their readable bits; unwritten words are unchanged.
- IDLE: when req_valid is high, latch channel, address and memAddress. Set cnt=0, go to DRE_RD and raise sel.
- sel is high in every state except IDLE.
- DRE_RD: ri_readAddress = base+cnt and ri_readChannel = channel; these are held constant until the next word. Go to DRE_CAP.
- DRE_CAP: register re_q=ri_readRe and all_q=ri_readData.
  - If re_q==4'hF, skip the word: go to NEXT with no memory access and no writes.
  - Otherwise go to MEM_REQ.
- MEM_REQ: mem_read=1 and mem_address = memAddress + 4*cnt. Hold both while mem_waitRequest is high. On the first cycle with mem_waitRequest low, go to MEM_WAIT.
- Only one read is outstanding at a time.
- MEM_WAIT: wait for mem_readDataValid, then register the data and go to WRITE. A mem_readDataValid in any other state is ignored.
- WRITE: one cycle.
  - Data RAM: dat_writeEnable=1, dat_writeByteEnable = ~re_q, dat_writeData = the registered word, at base+cnt on the latched channel.
  - Readable bits: ri_writeEnable=1 and ri_writeData = all_q | (address bit0 ? 8'hF0 : 8'h0F), at the same address and channel.
  - Go to NEXT.
- NEXT: if cnt==LINE_WORDS-1 go to DONE; otherwise cnt+1 and go to DRE_RD.
- cnt is $clog2(LINE_WORDS) bits wide.
- base+cnt is plain concatenation, so it never carries out of the line.
- DONE: done=1 for one cycle, then go to IDLE. sel drops on the IDLE cycle.
- A new request is accepted no earlier than the cycle after DONE.
- Latency for a word that is not skipped: 5 cycles + memory wait cycles + memory latency. A skipped word takes 3 cycles.
- Every word re-reads the readable byte after the previous word's write. This keeps the byte consistent for word pairs sharing one readable byte; the store's write-during-read forwarding covers back-to-back access.

Decomposition:
- Package cache_ri_pkg: the state enum (IDLE, DRE_RD, DRE_CAP, MEM_REQ, MEM_WAIT, WRITE, NEXT, DONE), and the half-masks 8'h0F and 8'hF0 as constants.
- Single module; no sub-module is needed.

Test Plan:
- Empty line: LINE_WORDS=8, all readable bits 0, zero-wait memory returning 0x1000+i. Required: 8 data writes with byteenable 4'hF and data 0x1000+i; readable bytes end 8'hFF at addresses base/2..base/2+3; done pulses once.
- CPU-written bytes: word 2 has re=4'b0101. Required: its data write uses byteenable 4'b1010; readable byte for words 2/3 ends 8'hFF; the other words are unaffected.
- Fully valid word: word 5 has re=4'hF. Required: no mem_read for memAddress+20 and no writes for word 5; total of 7 memory reads.
- Stall: mem_waitRequest high 3 cycles on word 0, then readDataValid 4 cycles after acceptance. Required: mem_read and mem_address stay stable during the stall; only one request is issued.
- Reset mid-refill: assert rst during MEM_WAIT of word 3. Required: outputs go to 0 with req_ready=1; readable bits for words 0-2 are set and words 3-7 are unchanged; a later request completes normally.
- Back-to-back requests: req_valid held high across DONE. Required: the second request is accepted in IDLE and sel is low for exactly that one cycle.

Source files
------------

// File: rtl/cache_ri_pkg.sv
// Shared definitions for the cache line-refill engine.
//   state_t   : refill FSM states
//   HALF_LO/HI: readable-byte half masks; an 8-bit readable byte covers two
//               words, the even word owns the low nibble, the odd word the high
//   halfMask  : picks the half mask from word-address bit 0
package cache_ri_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRE_RD,
    DRE_CAP,
    MEM_REQ,
    MEM_WAIT,
    WRITE,
    NEXT,
    DONE
  } state_t;

  localparam logic [7:0] HALF_LO = 8'h0F;
  localparam logic [7:0] HALF_HI = 8'hF0;

  function automatic logic [7:0] halfMask(input logic oddWord);
    return oddWord ? HALF_HI : HALF_LO;
  endfunction

endpackage

// File: rtl/cache_ri_refill.sv
// Line-refill engine for the data cache. On a miss request it walks one
// cache line word by word: reads the word's readable bits, fetches words that
// are not fully CPU-written from memory, merges them into the data RAM with
// byte enables that protect CPU-written bytes, and then marks the word
// readable. Sits directly upstream of the per-byte readable-bit store.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_*               refill request (valid/ready, way, line base, mem base)
//   done                one-cycle completion pulse
//   sel                 ownership of readable-bit store and data-RAM write port
//   ri_read*/ri_write*  readable-bit store ports (1-cycle read latency)
//   mem_*               memory bus read port (waitRequest stall, data strobe)
//   dat_*               data RAM write port
module cache_ri_refill
  import cache_ri_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int LINE_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_channel,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_memAddress,
  output logic                  done,
  output logic                  sel,
  output logic [ADDR_WIDTH-1:0] ri_readAddress,
  output logic [1:0]            ri_readChannel,
  input  logic [7:0]            ri_readData,
  input  logic [3:0]            ri_readRe,
  output logic [ADDR_WIDTH-1:0] ri_writeAddress,
  output logic [1:0]            ri_writeChannel,
  output logic                  ri_writeEnable,
  output logic [7:0]            ri_writeData,
  output logic [31:0]           mem_address,
  output logic                  mem_read,
  input  logic                  mem_waitRequest,
  input  logic                  mem_readDataValid,
  input  logic [31:0]           mem_readData,
  output logic [ADDR_WIDTH-1:0] dat_writeAddress,
  output logic [1:0]            dat_writeChannel,
  output logic [31:0]           dat_writeData,
  output logic [3:0]            dat_writeByteEnable,
  output logic                  dat_writeEnable
);

  localparam int CNT_W = $clog2(LINE_WORDS);

  state_t                      state;
  state_t                      stateNext;
  logic [CNT_W-1:0]            cnt;
  logic                        lastWord;

  logic [1:0]                  channel;
  logic [ADDR_WIDTH-CNT_W-1:0] lineTag;
  logic [31:0]                 memBase;
  logic [3:0]                  reQ;
  logic [7:0]                  allQ;
  logic [31:0]                 dataQ;

  logic [ADDR_WIDTH-1:0]       wordAddr;
  logic [31:0]                 wordMemAddr;

  // The request address is line-aligned; its offset bits carry no information.
  logic                        unusedOffsetBits;
  assign unusedOffsetBits = ^req_address[CNT_W-1:0];

  // Concatenation keeps the word address inside the line with no carry.
  assign wordAddr    = {lineTag, cnt};
  assign wordMemAddr = memBase + {{(30-CNT_W){1'b0}}, cnt, 2'b00};
  assign lastWord    = (cnt == CNT_W'(LINE_WORDS - 1));

  // Control state: the only registers that see reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && req_valid) begin
        cnt <= '0;
      end else if (state == NEXT && !lastWord) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Request fields and per-word captures; only observed while sel is high.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      channel <= req_channel;
      lineTag <= req_address[ADDR_WIDTH-1:CNT_W];
      memBase <= req_memAddress;
    end
    if (state == DRE_CAP) begin
      reQ  <= ri_readRe;
      allQ <= ri_readData;
    end
    if (state == MEM_WAIT && mem_readDataValid) begin
      dataQ <= mem_readData;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     if (req_valid) stateNext = DRE_RD;
      DRE_RD:   stateNext = DRE_CAP;
      // Decide on the live read data; reQ is loaded on this same edge.
      DRE_CAP:  stateNext = (ri_readRe == 4'hF) ? NEXT : MEM_REQ;
      MEM_REQ:  if (!mem_waitRequest) stateNext = MEM_WAIT;
      MEM_WAIT: if (mem_readDataValid) stateNext = WRITE;
      WRITE:    stateNext = NEXT;
      NEXT:     stateNext = lastWord ? DONE : DRE_RD;
      DONE:     stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // All outputs are gated by state so that reset/IDLE drives them to zero.
  always_comb begin
    req_ready           = 1'b0;
    sel                 = 1'b0;
    done                = 1'b0;
    ri_readAddress      = '0;
    ri_readChannel      = '0;
    ri_writeAddress     = '0;
    ri_writeChannel     = '0;
    ri_writeEnable      = 1'b0;
    ri_writeData        = '0;
    mem_address         = '0;
    mem_read            = 1'b0;
    dat_writeAddress    = '0;
    dat_writeChannel    = '0;
    dat_writeData       = '0;
    dat_writeByteEnable = '0;
    dat_writeEnable     = 1'b0;

    if (state == IDLE) begin
      req_ready = 1'b1;
    end else begin
      sel            = 1'b1;
      // Held for the whole word so the store's read port sees a stable address.
      ri_readAddress = wordAddr;
      ri_readChannel = channel;
    end

    if (state == MEM_REQ) begin
      mem_read    = 1'b1;
      mem_address = wordMemAddr;
    end

    if (state == WRITE) begin
      dat_writeEnable     = 1'b1;
      dat_writeByteEnable = ~reQ;
      dat_writeData       = dataQ;
      dat_writeAddress    = wordAddr;
      dat_writeChannel    = channel;
      // Keep the sibling word's half of the shared byte as it was read.
      ri_writeEnable      = 1'b1;
      ri_writeData        = allQ | halfMask(wordAddr[0]);
      ri_writeAddress     = wordAddr;
      ri_writeChannel     = channel;
    end

    if (state == DONE) begin
      done = 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_ri_refill.sv
// Bench for cache_ri_refill: readable-bit store, data RAM and memory models,
// a word-level expectation model feeding event queues, and a per-cycle checker.
module tb_cache_ri_refill;

  localparam int AW = 9;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_channel;
  logic [AW-1:0] req_address;
  logic [31:0]   req_memAddress;
  logic          done;
  logic          sel;
  logic [AW-1:0] ri_readAddress;
  logic [1:0]    ri_readChannel;
  logic [7:0]    ri_readData;
  logic [3:0]    ri_readRe;
  logic [AW-1:0] ri_writeAddress;
  logic [1:0]    ri_writeChannel;
  logic          ri_writeEnable;
  logic [7:0]    ri_writeData;
  logic [31:0]   mem_address;
  logic          mem_read;
  logic          mem_waitRequest;
  logic          mem_readDataValid = 1'b0;
  logic [31:0]   mem_readData = '0;
  logic [AW-1:0] dat_writeAddress;
  logic [1:0]    dat_writeChannel;
  logic [31:0]   dat_writeData;
  logic [3:0]    dat_writeByteEnable;
  logic          dat_writeEnable;

  cache_ri_refill #(.ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_channel(req_channel),
    .req_address(req_address), .req_memAddress(req_memAddress),
    .done(done), .sel(sel),
    .ri_readAddress(ri_readAddress), .ri_readChannel(ri_readChannel),
    .ri_readData(ri_readData), .ri_readRe(ri_readRe),
    .ri_writeAddress(ri_writeAddress), .ri_writeChannel(ri_writeChannel),
    .ri_writeEnable(ri_writeEnable), .ri_writeData(ri_writeData),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_waitRequest(mem_waitRequest), .mem_readDataValid(mem_readDataValid),
    .mem_readData(mem_readData),
    .dat_writeAddress(dat_writeAddress), .dat_writeChannel(dat_writeChannel),
    .dat_writeData(dat_writeData), .dat_writeByteEnable(dat_writeByteEnable),
    .dat_writeEnable(dat_writeEnable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h1000 + {2'b00, a[31:2]};
  endfunction

  // ---------------- readable-bit store model (1-cycle read, write forwarding)
  bit   [7:0]    rb [4][256];
  logic          cpuWe = 1'b0;
  logic [1:0]    cpuCh = '0;
  logic [7:0]    cpuAddr = '0;
  logic [7:0]    cpuData = '0;
  logic [7:0]    rdByte = '0;
  logic          rdOdd = 1'b0;

  always @(posedge clk) begin
    if (cpuWe) rb[cpuCh][cpuAddr] <= cpuData;
    if (ri_writeEnable) rb[ri_writeChannel][ri_writeAddress[AW-1:1]] <= ri_writeData;
    if (ri_writeEnable && ri_writeChannel == ri_readChannel &&
        ri_writeAddress[AW-1:1] == ri_readAddress[AW-1:1])
      rdByte <= ri_writeData;
    else
      rdByte <= rb[ri_readChannel][ri_readAddress[AW-1:1]];
    rdOdd <= ri_readAddress[0];
  end
  assign ri_readData = rdByte;
  assign ri_readRe   = rdOdd ? rdByte[7:4] : rdByte[3:0];

  // ---------------- data RAM model
  bit [31:0] dm [4][512];
  int        datWrites = 0;
  always @(posedge clk) begin
    if (dat_writeEnable) begin
      for (int b = 0; b < 4; b++)
        if (dat_writeByteEnable[b])
          dm[dat_writeChannel][dat_writeAddress][8*b +: 8] <= dat_writeData[8*b +: 8];
      datWrites <= datWrites + 1;
    end
  end

  // ---------------- memory model
  int          memLat = 1;
  int          stallCycles = 0;
  logic [31:0] stallAddr = 32'hFFFF_FFFF;
  int          stallCnt = 0;
  int          cd = 0;
  logic [31:0] pend = '0;
  int          memAccepts = 0;

  assign mem_waitRequest = mem_read && (mem_address == stallAddr) && (stallCnt < stallCycles);

  always @(posedge clk) begin
    mem_readDataValid <= 1'b0;
    if (!mem_read) stallCnt <= 0;
    else if (mem_waitRequest) stallCnt <= stallCnt + 1;
    if (mem_read && !mem_waitRequest) begin
      memAccepts <= memAccepts + 1;
      if (memLat <= 1) begin
        mem_readDataValid <= 1'b1;
        mem_readData      <= memWord(mem_address);
      end else begin
        cd   <= memLat - 1;
        pend <= memWord(mem_address);
      end
    end else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        mem_readDataValid <= 1'b1;
        mem_readData      <= pend;
      end
    end
  end

  // ---------------- expectation model
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [1:0]  ch;
  } ev_t;

  ev_t        expMem[$];
  ev_t        expDat[$];
  ev_t        expRi[$];
  bit [7:0]   img [4][256];
  logic [1:0] curCh = '0;

  // Walk the line a word at a time. The last (words-th) word may contribute
  // only its memory read when the refill is cut off while that read is pending.
  task automatic buildExp(input logic [1:0] ch, input logic [AW-1:0] base,
                          input logic [31:0] mb, input int words, input bit tailRead);
    for (int i = 0; i < words + (tailRead ? 1 : 0); i++) begin
      logic [AW-1:0] wa;
      logic [7:0]    byteNow;
      logic [7:0]    newb;
      logic [3:0]    nib;
      ev_t           e;
      wa      = base + AW'(i);
      byteNow = img[ch][wa[AW-1:1]];
      nib     = wa[0] ? byteNow[7:4] : byteNow[3:0];
      if (nib != 4'hF) begin
        e = '{a: mb + 32'(4 * i), d: '0, be: '0, ch: ch};
        expMem.push_back(e);
        if (i < words) begin
          e = '{a: 32'(wa), d: memWord(mb + 32'(4 * i)), be: ~nib, ch: ch};
          expDat.push_back(e);
          newb = byteNow | (wa[0] ? 8'hF0 : 8'h0F);
          e = '{a: 32'(wa), d: 32'(newb), be: '0, ch: ch};
          expRi.push_back(e);
          img[ch][wa[AW-1:1]] = newb;
        end
      end
    end
  endtask

  // ---------------- per-cycle checker
  logic        prevStall = 1'b0;
  logic [31:0] prevAddr = '0;
  int          doneCount = 0;
  int          stallSeen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      ev_t e;
      chk("req_ready_vs_sel", 32'(req_ready), 32'(!sel));
      if (sel) chk("ri_read_channel", 32'(ri_readChannel), 32'(curCh));
      if (prevStall) begin
        chk("stall_hold_read", 32'(mem_read), 32'd1);
        chk("stall_hold_addr", mem_address, prevAddr);
      end
      if (mem_read && mem_waitRequest) stallSeen <= stallSeen + 1;
      if (mem_read && !mem_waitRequest) begin
        if (expMem.size() == 0) chk("unexpected_mem_read", mem_address, 32'hDEAD_BEEF);
        else begin
          e = expMem.pop_front();
          chk("mem_address", mem_address, e.a);
        end
      end
      if (dat_writeEnable) begin
        if (expDat.size() == 0) chk("unexpected_dat_write", 32'(dat_writeAddress), 32'hDEAD_BEEF);
        else begin
          e = expDat.pop_front();
          chk("dat_addr", 32'(dat_writeAddress), e.a);
          chk("dat_channel", 32'(dat_writeChannel), 32'(e.ch));
          chk("dat_byteenable", 32'(dat_writeByteEnable), 32'(e.be));
          chk("dat_data", dat_writeData, e.d);
        end
      end
      if (ri_writeEnable) begin
        if (expRi.size() == 0) chk("unexpected_ri_write", 32'(ri_writeAddress), 32'hDEAD_BEEF);
        else begin
          e = expRi.pop_front();
          chk("ri_write_addr", 32'(ri_writeAddress), e.a);
          chk("ri_write_channel", 32'(ri_writeChannel), 32'(e.ch));
          chk("ri_write_data", 32'(ri_writeData), e.d);
        end
      end
      if (done) doneCount <= doneCount + 1;
      prevStall <= mem_read && mem_waitRequest;
      prevAddr  <= mem_address;
    end else begin
      prevStall <= 1'b0;
    end
  end

  // ---------------- stimulus helpers
  task automatic cpuWrite(input logic [1:0] ch, input logic [7:0] a, input logic [7:0] d);
    cpuCh = ch; cpuAddr = a; cpuData = d; cpuWe = 1'b1;
    @(posedge clk); #1;
    cpuWe = 1'b0;
  endtask

  // Present a request and return just after the edge that accepts it.
  task automatic issue(input logic [1:0] ch, input logic [AW-1:0] base, input logic [31:0] mb);
    bit ok;
    req_channel = ch; req_address = base; req_memAddress = mb; req_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) chk("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    curCh = ch;
    req_valid = 1'b0;
  endtask

  task automatic waitDone();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic checkDrained(input string tag);
    chk({tag, "_mem_left"}, 32'(expMem.size()), 32'd0);
    chk({tag, "_dat_left"}, 32'(expDat.size()), 32'd0);
    chk({tag, "_ri_left"},  32'(expRi.size()),  32'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_sel"},       32'(sel), 32'd0);
    chk({tag, "_done"},      32'(done), 32'd0);
    chk({tag, "_mem_read"},  32'(mem_read), 32'd0);
    chk({tag, "_mem_addr"},  mem_address, 32'd0);
    chk({tag, "_ri_raddr"},  32'(ri_readAddress), 32'd0);
    chk({tag, "_ri_we"},     32'(ri_writeEnable), 32'd0);
    chk({tag, "_dat_we"},    32'(dat_writeEnable), 32'd0);
  endtask

  // ---------------- directed sequence
  initial begin
    int d0, w0, a0, s0;
    bit ok;
    rst = 1'b1;
    req_valid = 1'b0; req_channel = '0; req_address = '0; req_memAddress = '0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty line, zero-wait memory.
    d0 = doneCount; w0 = datWrites; a0 = memAccepts;
    img = rb;
    buildExp(2'd0, 9'h000, 32'h0, LW, 1'b0);
    chk("model_empty_mem_reads", 32'(expMem.size()), 32'd8);
    issue(2'd0, 9'h000, 32'h0);
    waitDone();
    checkDrained("empty");
    for (int i = 0; i < LW; i++) chk("empty_dat_word", dm[0][i], 32'h1000 + 32'(i));
    for (int i = 0; i < 4; i++) chk("empty_ri_byte", 32'(rb[0][i]), 32'h0000_00FF);
    chk("empty_done_once", 32'(doneCount - d0), 32'd1);
    chk("empty_dat_writes", 32'(datWrites - w0), 32'd8);
    chk("empty_mem_reads", 32'(memAccepts - a0), 32'd8);

    // CPU already wrote bytes 0 and 2 of word 2.
    cpuWrite(2'd1, 8'h09, 8'h05);
    img = rb;
    buildExp(2'd1, 9'h010, 32'h200, LW, 1'b0);
    chk("model_cpu_be", 32'(expDat[2].be), 32'h0000_000A);
    issue(2'd1, 9'h010, 32'h200);
    waitDone();
    checkDrained("cpu");
    chk("cpu_word2_merge", dm[1][9'h012], 32'h0000_1000);
    chk("cpu_word3_full", dm[1][9'h013], 32'h0000_1083);
    chk("cpu_ri_byte", 32'(rb[1][8'h09]), 32'h0000_00FF);

    // Word 5 fully CPU-written: skipped entirely.
    cpuWrite(2'd2, 8'h12, 8'hF0);
    w0 = datWrites; a0 = memAccepts;
    img = rb;
    buildExp(2'd2, 9'h020, 32'h400, LW, 1'b0);
    chk("model_skip_mem_reads", 32'(expMem.size()), 32'd7);
    issue(2'd2, 9'h020, 32'h400);
    waitDone();
    checkDrained("skip");
    chk("skip_mem_reads", 32'(memAccepts - a0), 32'd7);
    chk("skip_dat_writes", 32'(datWrites - w0), 32'd7);
    chk("skip_word5_untouched", dm[2][9'h025], 32'd0);
    chk("skip_ri_byte", 32'(rb[2][8'h12]), 32'h0000_00FF);

    // Memory stall on word 0, slow return.
    stallAddr = 32'h800; stallCycles = 3; memLat = 4;
    s0 = stallSeen; a0 = memAccepts;
    img = rb;
    buildExp(2'd3, 9'h000, 32'h800, LW, 1'b0);
    issue(2'd3, 9'h000, 32'h800);
    waitDone();
    checkDrained("stall");
    chk("stall_cycles", 32'(stallSeen - s0), 32'd3);
    chk("stall_mem_reads", 32'(memAccepts - a0), 32'd8);
    stallCycles = 0; stallAddr = 32'hFFFF_FFFF;

    // Reset while word 3's read is outstanding.
    memLat = 6;
    w0 = datWrites; a0 = memAccepts;
    img = rb;
    buildExp(2'd0, 9'h040, 32'hC00, 3, 1'b1);
    issue(2'd0, 9'h040, 32'hC00);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (memAccepts - a0 == 4) ok = 1'b1;
    end
    if (!ok) chk("abort_reach_word3_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkIdleOutputs("abort");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    checkDrained("abort");
    chk("abort_dat_writes", 32'(datWrites - w0), 32'd3);
    chk("abort_ri_w01", 32'(rb[0][8'h20]), 32'h0000_00FF);
    chk("abort_ri_w23", 32'(rb[0][8'h21]), 32'h0000_000F);
    chk("abort_ri_w45", 32'(rb[0][8'h22]), 32'h0000_0000);
    chk("abort_ri_w67", 32'(rb[0][8'h23]), 32'h0000_0000);
    repeat (10) @(posedge clk);
    #1;
    memLat = 1;
    d0 = doneCount; a0 = memAccepts;
    img = rb;
    buildExp(2'd0, 9'h040, 32'hC00, LW, 1'b0);
    issue(2'd0, 9'h040, 32'hC00);
    waitDone();
    checkDrained("after_abort");
    chk("after_abort_mem_reads", 32'(memAccepts - a0), 32'd5);
    chk("after_abort_done", 32'(doneCount - d0), 32'd1);
    for (int i = 0; i < 4; i++) chk("after_abort_ri", 32'(rb[0][8'h20 + i]), 32'h0000_00FF);

    // Back-to-back requests with req_valid held across DONE.
    img = rb;
    buildExp(2'd1, 9'h080, 32'h1000, LW, 1'b0);
    buildExp(2'd2, 9'h0C0, 32'h2000, LW, 1'b0);
    d0 = doneCount;
    issue(2'd1, 9'h080, 32'h1000);
    req_channel = 2'd2; req_address = 9'h0C0; req_memAddress = 32'h2000; req_valid = 1'b1;
    begin
      int lowCnt;
      bit prevDone;
      lowCnt = 0; prevDone = 1'b0; ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
        @(negedge clk);
        if (!sel) begin
          lowCnt++;
          ok = 1'b1;
          chk("b2b_idle_after_done", 32'(prevDone), 32'd1);
        end
        prevDone = done;
      end
      if (!ok) chk("b2b_second_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      curCh = 2'd2;
      req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_sel_back_high", 32'(sel), 32'd1);
      chk("b2b_sel_low_cycles", 32'(lowCnt), 32'd1);
    end
    waitDone();
    checkDrained("b2b");
    chk("b2b_done_count", 32'(doneCount - d0), 32'd2);
    chk("b2b_ch2_word7", dm[2][9'h0C7], 32'h1000 + 32'h807);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
